// File: rtl/reg_file_clr.sv
// Parametrised 2-read/1-write register file with registered reads and write-to-read bypass.
// A clear sequencer zeroes the array after reset or on request, so no initial block is needed.
module reg_file_clr #(
    parameter int  XLEN     = 32,
    parameter int  DEPTH    = 32,
    parameter bit  ZERO_REG = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_req,
    output logic            ready,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re1,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rd1,
    input  logic            re2,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rd2
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_ptr;
    logic [AW-1:0]   clr_ptr_next;
    logic            write_en;
    logic [XLEN-1:0] rd1_next;
    logic [XLEN-1:0] rd2_next;
    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        ready        = 1'b0;
        case (state)
            CLEAR: begin
                clr_ptr_next = clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    state_next = READY;
                end
            end
            READY: begin
                ready = 1'b1;
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    // Writes to x0 are dropped when it is hardwired, which also disables bypass from them.
    assign write_en = (state == READY) && we && !(ZERO_REG && (waddr == '0));

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (write_en) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rd1_next = mem[raddr1];
        rd2_next = mem[raddr2];
        if (ZERO_REG && (raddr1 == '0)) begin
            rd1_next = '0;
        end else if (write_en && (waddr == raddr1)) begin
            rd1_next = wdata;
        end
        if (ZERO_REG && (raddr2 == '0)) begin
            rd2_next = '0;
        end else if (write_en && (waddr == raddr2)) begin
            rd2_next = wdata;
        end
    end

    // Read data is forced to zero for the whole sweep so nothing stale leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (state == CLEAR) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            if (re1) begin
                rd1 <= rd1_next;
            end
            if (re2) begin
                rd2 <= rd2_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed self-checking bench for reg_file_clr; a second instance with ZERO_REG=0
// shares all inputs so x0 behaviour can be compared in both configurations.
module tb_reg_file_clr;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic        ready;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        ready_nz;
    logic [31:0] rd1_nz;
    logic [31:0] rd2_nz;

    int checks = 0;
    int errors = 0;
    int n;

    reg_file_clr #(.XLEN(32), .DEPTH(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rd1(rd1),
        .re2(re2), .raddr2(raddr2), .rd2(rd2)
    );

    reg_file_clr #(.XLEN(32), .DEPTH(32), .ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_nz),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rd1(rd1_nz),
        .re2(re2), .raddr2(raddr2), .rd2(rd2_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic we_i, input logic [4:0] waddr_i,
                                 input logic [31:0] wdata_i,
                                 input logic re1_i, input logic [4:0] raddr1_i,
                                 input logic re2_i, input logic [4:0] raddr2_i,
                                 input logic clear_req_i);
        we        = we_i;
        waddr     = waddr_i;
        wdata     = wdata_i;
        re1       = re1_i;
        raddr1    = raddr1_i;
        re2       = re2_i;
        raddr2    = raddr2_i;
        clear_req = clear_req_i;
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                cycles = k;
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'b0, ready}, 32'd0);
        checkOutput("reset_rd1", rd1, 32'd0);
        checkOutput("reset_rd2", rd2, 32'd0);

        rst = 1'b0;
        waitReady(n);
        checkOutput("initial_sweep_len", n, 32'd32);

        // Preload nonzero contents, then reset asynchronously mid-cycle.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        checkOutput("preload_read_x9", rd1, 32'hCAFEF00D);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ready", {31'b0, ready}, 32'd0);
        checkOutput("async_rst_rd1", rd1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitReady(n);
        checkOutput("reset_sweep_len", n, 32'd32);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i), 1'b0);
            checkOutput($sformatf("swept_rd1_x%0d", i), rd1, 32'd0);
            checkOutput($sformatf("swept_rd2_x%0d", 31 - i), rd2, 32'd0);
        end

        // Write then read, with rd2 holding while re2=0.
        applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        checkOutput("load_rd2_x9", rd2, 32'hCAFEF00D);
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0);
        checkOutput("write_read_rd1", rd1, 32'hDEADBEEF);
        checkOutput("hold_rd2", rd2, 32'hCAFEF00D);

        // Same-cycle bypass on both ports, then the stored value.
        applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
        checkOutput("bypass_rd1", rd1, 32'h12345678);
        checkOutput("bypass_rd2", rd2, 32'h12345678);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd5, 1'b0);
        checkOutput("stored_x7", rd1, 32'h12345678);
        checkOutput("stored_x5", rd2, 32'hDEADBEEF);

        // x0 handling for both configurations.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("x0_same_cycle_zr1", rd1, 32'd0);
        checkOutput("x0_same_cycle_zr0", rd1_nz, 32'hFFFFFFFF);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("x0_next_cycle_zr1", rd1, 32'd0);
        checkOutput("x0_next_cycle_zr0", rd1_nz, 32'hFFFFFFFF);

        // clear_req collides with a write; writes during the sweep are dropped.
        applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1);
        checkOutput("collision_ready", {31'b0, ready}, 32'd0);
        checkOutput("collision_read", rd1, 32'hDEADBEEF);
        n = -1;
        for (int k = 1; k <= 64; k++) begin
            applyStimulus(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd3, 1'b1, 5'd5, 1'b0);
            checkOutput($sformatf("sweep_rd1_c%0d", k), rd1, 32'd0);
            if (ready) begin
                n = k;
                break;
            end
        end
        checkOutput("collision_sweep_len", n, 32'd32);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0);
        checkOutput("x3_after_sweep", rd1, 32'd0);
        checkOutput("x7_after_sweep", rd2, 32'd0);

        // Reset at sweep cycle 10 restarts the full sweep.
        applyStimulus(1'b1, 5'd4, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        end
        checkOutput("mid_sweep_ready", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", {31'b0, ready}, 32'd0);
        checkOutput("mid_rst_rd1", rd1, 32'd0);
        checkOutput("mid_rst_rd2", rd2, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitReady(n);
        checkOutput("restart_sweep_len", n, 32'd32);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd31, 1'b0);
        checkOutput("x4_after_restart", rd1, 32'd0);
        checkOutput("x31_after_restart", rd2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
